apb_master_bridge: RTL and testbench

- Single-outstanding APB initiator that drives the same APB bus our GPIO slave interface responds on.
- Converts a simple valid/ready command port (from CPU-side logic or a test sequencer) into APB SETUP/ACCESS phases.
- Waits for pready and returns read data or error status on a one-cycle response strobe.
- Includes a wait-state timeout so a hung slave cannot lock the bus.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_wait_timer.sv | 37 +++
 rtl/apb_master_bridge.sv | 124 ++++++++++++
 tb/tb_apb_master_bridge.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default widths for the APB master bridge.
//   apb_state_e  - bridge FSM state encoding (IDLE/SETUP/ACCESS)
//   APB_ADDR_W   - default paddr / cmd_addr width
//   APB_DATA_W   - default pwdata / prdata / response data width
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts consecutive ACCESS wait cycles and flags expiry.
//   pclk     in   clock
//   preset   in   synchronous active-low reset
//   clear    in   zero the counter (asserted in SETUP)
//   enable   in   this cycle is a wait cycle (ACCESS with pready low)
//   expired  out  this wait cycle is the TIMEOUT-th one; abort at the next edge
// TIMEOUT = 0 disables expiry entirely.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] cnt;

  // Saturates at LIMIT so a stale count never wraps back into range.
  always_ff @(posedge pclk) begin
    if (!preset || clear)
      cnt <= '0;
    else if (enable && cnt != LIMIT)
      cnt <= cnt + CNT_W'(1);
  end

  // Expiry is flagged in the wait cycle whose increment makes the count reach
  // TIMEOUT, so the transfer ends after exactly TIMEOUT unanswered ACCESS
  // cycles. The caller gives pready priority, so a ready in that same cycle
  // still completes normally.
  assign expired = (TIMEOUT != 0) && enable && (cnt == LIMIT - CNT_W'(1));

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: single-outstanding APB initiator.
// Accepts a valid/ready command, runs one APB SETUP/ACCESS transfer, and
// returns a one-cycle response strobe with read data / error status.
// A wait-state timer aborts transfers the slave never completes.
//
// Ports:
//   pclk, preset                    clock, synchronous active-low reset
//   cmd_valid/ready/write/addr/wdata command port
//   rsp_valid/rdata/err             response strobe (no backpressure)
//   psel/penable/pwrite/paddr/pwdata APB request
//   prdata/pready                   APB completion
//   pslverr                         APB slave error (only with APB_PSLVERR_EN)
//
// Build option: define APB_PSLVERR_EN to add the pslverr input and report it
// on rsp_err; otherwise rsp_err reflects timeouts only.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = APB_ADDR_W,
  parameter int DATA_W  = APB_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
`ifdef APB_PSLVERR_EN
  ,
  input  logic              pslverr
`endif
);

  apb_state_e state;
  logic       tmr_expired;
  logic       slv_err;

`ifdef APB_PSLVERR_EN
  assign slv_err = pslverr;
`else
  assign slv_err = 1'b0;
`endif

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .pclk    (pclk),
    .preset  (preset),
    .clear   (state == SETUP),
    .enable  ((state == ACCESS) && !pready),
    .expired (tmr_expired)
  );

  always_ff @(posedge pclk) begin
    if (!preset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // Response is a single-cycle strobe.
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            paddr     <= cmd_addr;
            pwdata    <= cmd_wdata;
            pwrite    <= cmd_write;
            psel      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over expiry in the same cycle.
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= slv_err;
            rsp_rdata <= (pwrite || slv_err) ? '0 : prdata;
            state     <= IDLE;
          end else if (tmr_expired) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          psel    <= 1'b0;
          penable <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed stimulus with a response scoreboard.
// Stimulus pushes the expected {err, rdata} when a command is issued; a
// separate monitor pops and compares on every rsp_valid. APB phase timing is
// checked inline by the stimulus. Instantiated with TIMEOUT = 4.
module tb_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  typedef struct packed {
    logic          err;
    logic [DW-1:0] rdata;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .pclk      (pclk),
    .preset    (preset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .psel      (psel),
    .penable   (penable),
    .pwrite    (pwrite),
    .paddr     (paddr),
    .pwdata    (pwdata),
    .prdata    (prdata),
    .pready    (pready)
`ifdef APB_PSLVERR_EN
    ,
    .pslverr   (pslverr)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge pclk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp_valid", 64'(rsp_valid), 64'(0));
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic wait_ready();
    int k;
    for (k = 0; k < 20 && !cmd_ready; k++) @(negedge pclk);
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
  endtask

  // One transfer. waits < 0 means the slave never answers (timeout expected).
  task automatic xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input int waits, input logic [DW-1:0] rd, input logic serr);
    int   ncyc;
    rsp_t e;
    wait_ready();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd;
    if (waits < 0) e = '{err: 1'b1, rdata: '0};
    else if (serr) e = '{err: 1'b1, rdata: '0};
    else e = '{err: 1'b0, rdata: wr ? '0 : rd};
    exp_q.push_back(e);
    @(negedge pclk);                        // SETUP cycle
    cmd_valid = 1'b0;
    chk("setup_psel", 64'(psel), 64'(1));
    chk("setup_penable", 64'(penable), 64'(0));
    chk("setup_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("setup_paddr", 64'(paddr), 64'(a));
    chk("setup_pwrite", 64'(pwrite), 64'(wr));
    ncyc = (waits < 0) ? TO : waits + 1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge pclk);                      // ACCESS cycle i
      chk("access_psel", 64'(psel), 64'(1));
      chk("access_penable", 64'(penable), 64'(1));
      chk("access_paddr", 64'(paddr), 64'(a));
      if (wr) chk("access_pwdata", 64'(pwdata), 64'(wd));
      if (waits >= 0 && i == ncyc - 1) begin
        pready = 1'b1; prdata = rd; pslverr = serr;
      end
    end
    @(negedge pclk);                        // back in IDLE, response cycle
    pready = 1'b0; prdata = 32'h1357_9BDF; pslverr = 1'b0;
    chk("done_psel", 64'(psel), 64'(0));
    chk("done_penable", 64'(penable), 64'(0));
    chk("done_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("done_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("retain_paddr", 64'(paddr), 64'(a));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge pclk);
    chk("rst_psel", 64'(psel), 64'(0));
    chk("rst_penable", 64'(penable), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_paddr", 64'(paddr), 64'(0));
    preset = 1'b1;
    @(negedge pclk);
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'(1));

    // Write, no wait states
    xfer(1'b1, 32'h04, 32'hDEADBEEF, 0, 32'h0, 1'b0);
    // Read, 3 wait states (pready lands on the timeout cycle too)
    xfer(1'b0, 32'h08, 32'h0, 3, 32'h0000A5A5, 1'b0);
    // Read, 1 wait state
    xfer(1'b0, 32'h0C, 32'h0, 1, 32'hCAFE0001, 1'b0);
    // Write with 2 wait states
    xfer(1'b1, 32'h10, 32'h12345678, 2, 32'hFFFFFFFF, 1'b0);
    // Timeout: slave never answers
    xfer(1'b0, 32'h14, 32'h0, -1, 32'h0, 1'b0);

    // pready outside ACCESS is ignored
    pready = 1'b1;
    repeat (3) @(negedge pclk);
    chk("idle_pready_psel", 64'(psel), 64'(0));
    chk("idle_pready_rsp", 64'(rsp_valid), 64'(0));
    pready = 1'b0;

    // Reset during ACCESS aborts without a response
    wait_ready();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20;
    @(negedge pclk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge pclk);
    chk("pre_rst_penable", 64'(penable), 64'(1));
    preset = 1'b0;
    @(negedge pclk);
    chk("midrst_psel", 64'(psel), 64'(0));
    chk("midrst_penable", 64'(penable), 64'(0));
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
    preset = 1'b1;
    @(negedge pclk);
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_rsp_valid2", 64'(rsp_valid), 64'(0));

    // Normal transfer after the abort
    xfer(1'b0, 32'h24, 32'h0, 0, 32'h00C0FFEE, 1'b0);
`ifdef APB_PSLVERR_EN
    xfer(1'b0, 32'h28, 32'h0, 0, 32'hBAD0BAD0, 1'b1);
`endif

    repeat (3) @(negedge pclk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
